// File: rtl/mul_iter_unit.sv
// Iterative RV32M multiplier: radix-2 shift-add over a WIDTH-bit CLA built from 4-bit slices.
// Operands are reduced to magnitudes at accept time; the sign is re-applied to the full product.
module mul_iter_unit #(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int NS = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] mcand, mplier, acc_hi;

  logic             a_sgn, b_sgn, a_neg, b_neg, zero_op;
  logic [WIDTH-1:0] a_mag, b_mag, addend, sum;
  logic             add_co, cy;
  logic [3:0]       g4, p4, c4;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_sgn   = (op == 2'b01) || (op == 2'b10);
  assign b_sgn   = (op == 2'b01);
  assign a_neg   = a_sgn & a[WIDTH-1];
  assign b_neg   = b_sgn & b[WIDTH-1];
  // The most negative value negates onto itself, which is exactly its magnitude when read unsigned.
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign zero_op = (a == '0) || (b == '0);

  assign addend  = mplier[0] ? mcand : '0;

  always_comb begin
    cy  = 1'b0;
    sum = '0;
    g4  = '0;
    p4  = '0;
    c4  = '0;
    for (int s = 0; s < NS; s++) begin
      g4    = acc_hi[4*s +: 4] & addend[4*s +: 4];
      p4    = acc_hi[4*s +: 4] ^ addend[4*s +: 4];
      c4[0] = cy;
      c4[1] = g4[0] | (p4[0] & cy);
      c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cy);
      c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & cy);
      sum[4*s +: 4] = p4 ^ c4;
      cy = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]) | ((&p4) & cy);
    end
    add_co = cy;
  end

  assign prod     = {acc_hi, mplier};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (FAST_ZERO && zero_op) ? DONE : CALC;
      CALC: if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            neg_q  <= a_neg ^ b_neg;
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            count  <= '0;
            if (FAST_ZERO && zero_op) result <= '0;
          end
        end
        CALC: begin
          // Adder carry-out becomes the top bit as the accumulator shifts right.
          {acc_hi, mplier} <= {add_co, sum, mplier[WIDTH-1:1]};
          count            <= count + 1'b1;
        end
        FIX: result <= (op_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: directed corner products plus random ops against a 64-bit arithmetic model,
// run on a fast-zero and a full-latency instance side by side.
module tb_mul_iter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] res_f, res_s;
  logic [31:0] last_f = '0, last_s = '0;
  logic [31:0] rf, rs;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  mul_iter_unit #(.WIDTH(32), .FAST_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy_f), .done(done_f), .result(res_f)
  );

  mul_iter_unit #(.WIDTH(32), .FAST_ZERO(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy_s), .done(done_s), .result(res_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] p;
    sx = (f == 2'b01 || f == 2'b10) ? longint'($signed(x)) : longint'({32'd0, x});
    sy = (f == 2'b01) ? longint'($signed(y)) : longint'({32'd0, y});
    p  = 64'(sx * sy);
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op, disturbs inputs while busy, and checks latency, pulse width, busy and result.
  task automatic run_op(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r_f, output logic [31:0] r_s);
    int          lat_f, lat_s, pul_f, pul_s, bb_f, bb_s, exp_lat_f;
    logic [31:0] expv;
    expv      = ref_mul(f, x, y);
    exp_lat_f = (x == 0 || y == 0) ? 1 : 34;
    lat_f = 0; lat_s = 0; pul_f = 0; pul_s = 0; bb_f = 0; bb_s = 0;
    r_f = '0; r_s = '0;
    @(negedge clk);
    chk("hold_before_f", res_f, last_f);
    chk("hold_before_s", res_s, last_s);
    op = f; a = x; b = y; start = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin
        op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (n == 2 && exp_lat_f != 1) start = 1'b1;
      if (done_f) begin
        pul_f++;
        if (lat_f == 0) begin lat_f = n; r_f = res_f; end
      end
      if (done_s) begin
        pul_s++;
        if (lat_s == 0) begin lat_s = n; r_s = res_s; end
      end
      if (busy_f !== (n <= exp_lat_f)) bb_f++;
      if (busy_s !== (n <= 34)) bb_s++;
    end
    chk("latency_f", 64'(lat_f), 64'(exp_lat_f));
    chk("latency_s", 64'(lat_s), 64'd34);
    chk("pulses_f", 64'(pul_f), 64'd1);
    chk("pulses_s", 64'(pul_s), 64'd1);
    chk("busy_f", 64'(bb_f), 64'd0);
    chk("busy_s", 64'(bb_s), 64'd0);
    chk("result_f", r_f, expv);
    chk("result_s", r_s, expv);
    chk("hold_after_f", res_f, r_f);
    chk("hold_after_s", res_s, r_s);
    last_f = r_f;
    last_s = r_s;
  endtask

  initial begin
    int pulses;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy_f", busy_f, 1'b0);
    chk("rst_done_f", done_f, 1'b0);
    chk("rst_result_f", res_f, 32'h0);
    chk("rst_busy_s", busy_s, 1'b0);
    chk("rst_result_s", res_s, 32'h0);
    rst = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, rf, rs);
    chk("mul_7x6", rf, 32'h0000_002A);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, rf, rs);
    chk("mulh_min", rf, 32'h4000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, rf, rs);
    chk("mul_min", rf, 32'h0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rf, rs);
    chk("mulhsu_ones", rf, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rf, rs);
    chk("mulhu_ones", rf, 32'hFFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rf, rs);
    chk("mulh_ones", rf, 32'h0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rf, rs);
    chk("mul_ones", rf, 32'h1);
    run_op(2'b11, 32'h0, 32'h1234_5678, rf, rs);
    chk("mulhu_zero_f", rf, 32'h0);
    chk("mulhu_zero_s", rs, 32'h0);

    // Abort mid-operation with reset; the extra start at cycle 5 must be ignored.
    pulses = 0;
    @(negedge clk);
    op = 2'b00; a = 32'd123; b = 32'd456; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_f || done_s) pulses++;
      if (n == 5) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (n == 10) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort_busy_f", busy_f, 1'b0);
    chk("abort_done_f", done_f, 1'b0);
    chk("abort_busy_s", busy_s, 1'b0);
    chk("abort_done_s", done_s, 1'b0);
    chk("abort_result_f", res_f, 32'h0);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_f || done_s) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    last_f = '0;
    last_s = '0;
    run_op(2'b00, 32'd3, 32'd5, rf, rs);
    chk("mul_3x5", rf, 32'd15);

    for (int i = 0; i < 800; i++) begin
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, rf, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
